acc_reg_file: RTL
=================

# acc_reg_file

Parametrised accumulator-centred register file for the CSE141L datapath. It replaces the fixed 8×16 accumulator file with configurable width, depth and accumulator/scratch indices, and adds an explicit opcode interface with swap. It also adds a multi-cycle lookup-table load with stall handshake and a soft clear sequencer. It sits between the decoder, ALU and LUT, feeding the ALU its two implicit operands and the instruction operand register.

## Interface
- `W`, 8, data width in bits
- `D`, 4, address width; depth is 2**D entries
- `ACC`, 0, index of accumulator register
- `SCR`, 1, index of scratch (second ALU operand) register
- `clk`  input  1  rising-edge clock
- `reset`  input  1  asynchronous, active-high reset
- `op`  input  3  operation code (`rf_pkg::rf_op_e`)
- `addr`  input  D  register index for the operand/move operations
- `alu_result`  input  W  value written to the accumulator by WR_ALU
- `lut_valid`  input  1  LUT data valid strobe
- `lut_data`  input  W  LUT return value
- `clr_start`  input  1  request a soft clear of all entries
- `insn_operand`  output  W  combinational read of reg[addr]
- `read_a`  output  W  combinational read of reg[ACC]
- `read_b`  output  W  combinational read of reg[SCR]
- `stall`  output  1  high while state ≠ IDLE; ops are not accepted
- `clr_busy`  output  1  high while state = CLEAR
- `op_err`  output  1  registered one-cycle pulse on a rejected or illegal op

## Operation
Opcodes:
- 0 NOP
- 1 MOV_TO: reg[addr] ← reg[ACC]
- 2 MOV_FROM: reg[ACC] ← reg[addr]
- 3 SWAP: reg[ACC] and reg[addr] exchanged in one edge
- 4 WR_ALU: reg[ACC] ← alu_result
- 5 WR_LUT: LUT load into reg[ACC]
- 6–7 reserved: no state change; op_err pulses

With `addr == ACC`, MOV_TO, MOV_FROM and SWAP leave all contents unchanged and are legal (no op_err).

FSM states: IDLE, LUT_WAIT, CLEAR.
- **IDLE**
  - `clr_start=1` has priority over any op. The op that cycle is dropped without op_err. The counter is set to 0 and the FSM enters CLEAR.
  - WR_LUT with `lut_valid=1` in the same cycle writes `lut_data` to reg[ACC] and the FSM stays in IDLE.
  - WR_LUT with `lut_valid=0` enters LUT_WAIT with no write.
  - All other ops execute at the edge; the FSM stays in IDLE.
- **LUT_WAIT**
  - On `lut_valid=1`: reg[ACC] ← lut_data, then go to IDLE.
  - `clr_start` is ignored.
  - Any non-NOP op causes an op_err pulse and is discarded; the decoder must hold it.
- **CLEAR**
  - Each cycle writes reg[cnt] ← 0 and increments cnt.
  - When cnt = 2**D−1, that last entry is written and the FSM goes to IDLE.
  - Non-NOP ops cause op_err and are discarded; `clr_start` and `lut_valid` are ignored.
- The counter is D+1 bits wide; the terminal compare is on the low D bits equal to all-ones. No wrap occurs within the sequence.
- No arithmetic is done on data; all writes are full W bits.

## Timing
- Reset values (asynchronous, immediate):
  - all 2**D entries = 0, so insn_operand, read_a and read_b = 0
  - state = IDLE, so stall = 0 and clr_busy = 0
  - op_err = 0, cnt = 0
- Reset asserted mid-LUT_WAIT or mid-CLEAR aborts immediately to IDLE. A late `lut_valid` after reset is ignored unless WR_LUT is reissued.
- Write latency is 1 cycle. Read ports are combinational from the array, so a write at edge N is visible on the outputs after edge N. There is no same-cycle bypass.
- stall and clr_busy are decoded from the state register (glitch-free, registered state).
  - stall rises the cycle after the WR_LUT or clr_start edge.
- CLEAR occupies exactly 2**D cycles: clr_busy is high for 2**D cycles. The first op is accepted in the cycle after clr_busy falls.
- LUT latency is unbounded; the block waits indefinitely in LUT_WAIT.
- op_err is asserted for the single cycle after the offending op is sampled.

## Structure
- Package `rf_pkg` contains:
  - `rf_op_e` (3-bit enum: NOP, MOV_TO, MOV_FROM, SWAP, WR_ALU, WR_LUT)
  - `rf_state_e` (IDLE, LUT_WAIT, CLEAR)
- One sub-module, `rf_storage`: the 2**D×W array with asynchronous reset, one combinational read port per output, and two write ports.
  - Port A: any index.
  - Port B: accumulator only; used for SWAP and for all accumulator writes.
  - Simultaneous writes to the same index never occur, by construction.
- The top level holds the FSM, the clear counter, op decode and op_err.

## Test plan
- **Reset and move.** Sequence: reset; WR_ALU 0x5A; MOV_TO addr 3; WR_ALU 0x11; SWAP addr 3. Expected: read_a = 0x5A and reg3 = 0x11. Then MOV_FROM addr 3 gives read_a = 0x11.
- **Immediate LUT.** WR_LUT with lut_valid=1 and lut_data=0xC3 in the same cycle. Expected: read_a = 0xC3 next cycle, stall never asserted.
- **Delayed LUT.** WR_LUT with lut_valid=0, then lut_valid held low for 4 cycles with MOV_TO issued during the wait, then lut_valid=1 with lut_data=0x7E. Expected: stall high for 5 cycles; op_err pulses once per MOV_TO; read_a = 0x7E afterwards; MOV_TO target unchanged.
- **Soft clear.** Fill all 16 entries with nonzero values; pulse clr_start together with WR_ALU 0xFF. Expected: clr_busy high exactly 16 cycles, all entries 0 afterwards, WR_ALU dropped, no op_err.
- **Reset mid-clear.** Assert reset in cycle 5 of CLEAR. Expected: immediate IDLE with all entries 0; a subsequent WR_ALU 0x22 is accepted on the first edge after reset deasserts.
- **Illegal opcode.** op = 6 in IDLE. Expected: one op_err pulse; all registers unchanged.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared types for the accumulator-centred register file: opcodes and
// sequencer states.
package rf_pkg;

  typedef enum logic [2:0] {
    NOP      = 3'd0,
    MOV_TO   = 3'd1,
    MOV_FROM = 3'd2,
    SWAP     = 3'd3,
    WR_ALU   = 3'd4,
    WR_LUT   = 3'd5
  } rf_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LUT_WAIT = 2'd1,
    CLEAR    = 2'd2
  } rf_state_e;

  // Codes 6 and 7 are reserved and must raise op_err when seen in IDLE.
  function automatic logic op_is_legal(input logic [2:0] code);
    return code <= 3'd5;
  endfunction

endpackage

// File: rtl/rf_storage.sv
// 2**D x W register array: port A writes any entry, port B writes only the
// accumulator; three combinational read ports.
module rf_storage #(
  parameter int W   = 8,
  parameter int D   = 4,
  parameter int ACC = 0,
  parameter int SCR = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we_a_i,
  input  logic [D-1:0] waddr_a_i,
  input  logic [W-1:0] wdata_a_i,
  input  logic         we_b_i,
  input  logic [W-1:0] wdata_b_i,
  input  logic [D-1:0] raddr_i,
  output logic [W-1:0] rd_insn_o,
  output logic [W-1:0] rd_acc_o,
  output logic [W-1:0] rd_scr_o
);

  localparam int          DEPTH   = 2 ** D;
  localparam logic [D-1:0] ACC_IDX = D'(ACC);
  localparam logic [D-1:0] SCR_IDX = D'(SCR);

  logic [W-1:0] mem_q [DEPTH];

  // The two ports never target the same entry in one cycle, so their
  // order here carries no priority meaning.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (we_a_i) mem_q[waddr_a_i] <= wdata_a_i;
      if (we_b_i) mem_q[ACC_IDX]   <= wdata_b_i;
    end
  end

  assign rd_insn_o = mem_q[raddr_i];
  assign rd_acc_o  = mem_q[ACC_IDX];
  assign rd_scr_o  = mem_q[SCR_IDX];

endmodule

// File: rtl/acc_reg_file.sv
// Accumulator register file: op decode, LUT-load wait state, soft clear
// sequencer and op_err generation around the rf_storage array.
module acc_reg_file
  import rf_pkg::*;
#(
  parameter int W   = 8,
  parameter int D   = 4,
  parameter int ACC = 0,
  parameter int SCR = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [2:0]   op,
  input  logic [D-1:0] addr,
  input  logic [W-1:0] alu_result,
  input  logic         lut_valid,
  input  logic [W-1:0] lut_data,
  input  logic         clr_start,
  output logic [W-1:0] insn_operand,
  output logic [W-1:0] read_a,
  output logic [W-1:0] read_b,
  output logic         stall,
  output logic         clr_busy,
  output logic         op_err
);

  localparam logic [D-1:0] ACC_IDX = D'(ACC);

  rf_state_e    state_q;
  logic [D:0]   cnt_q;
  logic         op_err_q;

  logic         we_a;
  logic [D-1:0] waddr_a;
  logic [W-1:0] wdata_a;
  logic         we_b;
  logic [W-1:0] wdata_b;
  logic         acc_sel;

  assign acc_sel = (addr == ACC_IDX);

  // Moves and swaps that target the accumulator itself are no-ops.
  always_comb begin
    we_a    = 1'b0;
    waddr_a = addr;
    wdata_a = read_a;
    we_b    = 1'b0;
    wdata_b = insn_operand;
    case (state_q)
      IDLE: begin
        if (!clr_start) begin
          case (rf_op_e'(op))
            MOV_TO:   we_a = !acc_sel;
            MOV_FROM: we_b = !acc_sel;
            SWAP: begin
              we_a = !acc_sel;
              we_b = !acc_sel;
            end
            WR_ALU: begin
              we_b    = 1'b1;
              wdata_b = alu_result;
            end
            WR_LUT: begin
              we_b    = lut_valid;
              wdata_b = lut_data;
            end
            default: ;
          endcase
        end
      end
      LUT_WAIT: begin
        we_b    = lut_valid;
        wdata_b = lut_data;
      end
      CLEAR: begin
        we_a    = 1'b1;
        waddr_a = cnt_q[D-1:0];
        wdata_a = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_err_q <= 1'b0;
    end else begin
      op_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_start) begin
            cnt_q   <= '0;
            state_q <= CLEAR;
          end else begin
            op_err_q <= !op_is_legal(op);
            if (op == WR_LUT && !lut_valid) state_q <= LUT_WAIT;
          end
        end
        LUT_WAIT: begin
          op_err_q <= (op != NOP);
          if (lut_valid) state_q <= IDLE;
        end
        CLEAR: begin
          op_err_q <= (op != NOP);
          cnt_q    <= cnt_q + 1'b1;
          // The MSB cannot set inside a sequence; it only backs up the exit.
          if ((&cnt_q[D-1:0]) || cnt_q[D]) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign stall    = (state_q != IDLE);
  assign clr_busy = (state_q == CLEAR);
  assign op_err   = op_err_q;

  rf_storage #(
    .W  (W),
    .D  (D),
    .ACC(ACC),
    .SCR(SCR)
  ) u_storage (
    .clk      (clk),
    .reset    (reset),
    .we_a_i   (we_a),
    .waddr_a_i(waddr_a),
    .wdata_a_i(wdata_a),
    .we_b_i   (we_b),
    .wdata_b_i(wdata_b),
    .raddr_i  (addr),
    .rd_insn_o(insn_operand),
    .rd_acc_o (read_a),
    .rd_scr_o (read_b)
  );

endmodule
